// File: rtl/output_pkg.sv
// rtl/output_pkg.sv - shared types and constants for the output scheduler and emitter
package output_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } sched_state_t;

    localparam int OUT_DATA_WIDTH = 16;

    // Next index after idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/output_emitter.sv
// rtl/output_emitter.sv - LSB-first serializer; counter and done clear whenever start is low
import output_pkg::*;

module output_emitter #(
    parameter int INPUT_WIDTH = OUT_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [INPUT_WIDTH-1:0] data,
    output logic                   serial_out,
    output logic                   serial_done
);

    localparam int CW = $clog2(INPUT_WIDTH + 1);
    localparam int IW = $clog2(INPUT_WIDTH);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            serial_out  <= 1'b0;
            serial_done <= 1'b0;
        end else if (!start) begin
            r_cnt       <= '0;
            serial_out  <= 1'b0;
            serial_done <= 1'b0;
        end else begin
            if (r_cnt != CW'(INPUT_WIDTH)) begin
                serial_out <= data[r_cnt[IW-1:0]];
                r_cnt      <= r_cnt + CW'(1);
            end
            serial_done <= (r_cnt == CW'(INPUT_WIDTH));
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDW = $clog2(NUM_REQ);

    int w_idx;

    // Scan from farthest to nearest so the closest set bit at or above rr_ptr wins.
    always_comb begin
        valid     = 1'b0;
        grant_idx = '0;
        w_idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (req[w_idx]) begin
                valid     = 1'b1;
                grant_idx = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/output_scheduler.sv
// rtl/output_scheduler.sv - round-robin sharing of one output_emitter among NUM_REQ requesters
import output_pkg::*;

module output_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = OUT_DATA_WIDTH,
    parameter int TIMEOUT    = DATA_WIDTH + 4
) (
    input  logic                          fast_clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          err,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [DATA_WIDTH-1:0]         emit_data,
    output logic                          emit_start,
    input  logic                          emit_done
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT + 1);

    sched_state_t          r_state;
    logic [IDW-1:0]        r_rr_ptr;
    logic [WDW-1:0]        r_wdog;

    sched_state_t          w_state_nxt;
    logic [IDW-1:0]        w_rr_ptr_nxt;
    logic [WDW-1:0]        w_wdog_nxt;
    logic [IDW-1:0]        w_grant_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_start_nxt;
    logic [NUM_REQ-1:0]    w_ack_nxt;
    logic                  w_err_nxt;
    logic                  w_pick_valid;
    logic [IDW-1:0]        w_pick_idx;
    int                    w_base;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req),
        .rr_ptr    (r_rr_ptr),
        .valid     (w_pick_valid),
        .grant_idx (w_pick_idx)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_wdog_nxt   = r_wdog;
        w_grant_nxt  = grant_id;
        w_data_nxt   = emit_data;
        w_start_nxt  = emit_start;
        w_ack_nxt    = '0;
        w_err_nxt    = 1'b0;
        w_base       = int'(w_pick_idx) * DATA_WIDTH;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = w_pick_idx;
                    w_data_nxt  = req_data[w_base +: DATA_WIDTH];
                    w_start_nxt = 1'b1;
                    w_wdog_nxt  = '0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // Done wins over a watchdog expiry in the same cycle.
                if (emit_done) begin
                    w_start_nxt         = 1'b0;
                    w_ack_nxt[grant_id] = 1'b1;
                    w_state_nxt         = ST_RELEASE;
                end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                    w_start_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_wdog_nxt = r_wdog + WDW'(1);
                end
            end
            ST_RELEASE: begin
                w_rr_ptr_nxt = IDW'(wrap_inc(int'(grant_id), NUM_REQ));
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_start_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_wdog     <= '0;
            grant_id   <= '0;
            emit_data  <= '0;
            emit_start <= 1'b0;
            ack        <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_wdog     <= w_wdog_nxt;
            grant_id   <= w_grant_nxt;
            emit_data  <= w_data_nxt;
            emit_start <= w_start_nxt;
            ack        <= w_ack_nxt;
            err        <= w_err_nxt;
            busy       <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_output_scheduler.sv
// tb/tb_output_scheduler.sv - directed bench for output_scheduler driving output_emitter
module tb_output_scheduler;

    logic        fast_clk;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic        err;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] emit_data;
    logic        emit_start;
    logic        serial_out;
    logic        serial_done;
    logic        done_en;
    logic        emit_done;

    logic [3:0]  req2;
    logic [63:0] req_data2;
    logic [3:0]  ack2;
    logic        err2;
    logic        busy2;
    logic [1:0]  grant_id2;
    logic [15:0] emit_data2;
    logic        emit_start2;
    logic        serial_out2;
    logic        serial_done2;

    logic        emit_rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    assign emit_rst_n = ~reset;
    assign emit_done  = done_en & serial_done;

    output_scheduler #(.NUM_REQ(4), .DATA_WIDTH(16), .TIMEOUT(20)) u_dut (
        .fast_clk   (fast_clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .err        (err),
        .busy       (busy),
        .grant_id   (grant_id),
        .emit_data  (emit_data),
        .emit_start (emit_start),
        .emit_done  (emit_done)
    );

    output_emitter #(.INPUT_WIDTH(16)) u_emit (
        .clk         (fast_clk),
        .rst_n       (emit_rst_n),
        .start       (emit_start),
        .data        (emit_data),
        .serial_out  (serial_out),
        .serial_done (serial_done)
    );

    output_scheduler #(.NUM_REQ(4), .DATA_WIDTH(16), .TIMEOUT(18)) u_dut2 (
        .fast_clk   (fast_clk),
        .reset      (reset),
        .req        (req2),
        .req_data   (req_data2),
        .ack        (ack2),
        .err        (err2),
        .busy       (busy2),
        .grant_id   (grant_id2),
        .emit_data  (emit_data2),
        .emit_start (emit_start2),
        .emit_done  (serial_done2)
    );

    output_emitter #(.INPUT_WIDTH(16)) u_emit2 (
        .clk         (fast_clk),
        .rst_n       (emit_rst_n),
        .start       (emit_start2),
        .data        (emit_data2),
        .serial_out  (serial_out2),
        .serial_done (serial_done2)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic capture_word(output logic [15:0] w);
        for (int k = 0; k < 16; k++) begin
            tick();
            w[k] = serial_out;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [15:0] word;
        logic [3:0]  exp_gnt [5];
        int          n_grant;
        int          n_ack;
        logic        prev_start;
        logic [3:0]  acc_ack;
        logic        acc_err;

        reset     = 1'b1;
        req       = '0;
        req_data  = '0;
        req2      = '0;
        req_data2 = '0;
        done_en   = 1'b1;
        #1;
        check_val("rst_ack",   {28'd0, ack}, 32'h0);
        check_val("rst_err",   {31'd0, err}, 32'h0);
        check_val("rst_busy",  {31'd0, busy}, 32'h0);
        check_val("rst_gnt",   {30'd0, grant_id}, 32'h0);
        check_val("rst_data",  {16'd0, emit_data}, 32'h0);
        check_val("rst_start", {31'd0, emit_start}, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Single request on requester 1
        req              = 4'b0010;
        req_data[31:16]  = 16'hA5C3;
        tick();
        check_val("single_start", {31'd0, emit_start}, 32'h1);
        check_val("single_busy",  {31'd0, busy}, 32'h1);
        check_val("single_gnt",   {30'd0, grant_id}, 32'h1);
        check_val("single_data",  {16'd0, emit_data}, 32'hA5C3);
        capture_word(word);
        check_val("single_serial", {16'd0, word}, 32'hA5C3);
        tick();
        check_val("single_ack_t18", {28'd0, ack}, 32'h0);
        tick();
        check_val("single_ack_t19", {28'd0, ack}, 32'h2);
        check_val("single_err_t19", {31'd0, err}, 32'h0);
        req = '0;
        tick();
        check_val("single_ack_t20",  {28'd0, ack}, 32'h0);
        check_val("single_busy_t20", {31'd0, busy}, 32'h0);

        // All four requesting continuously from rr_ptr = 0
        do_reset();
        req        = 4'b1111;
        req_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        exp_gnt    = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        n_grant    = 0;
        n_ack      = 0;
        prev_start = 1'b0;
        for (int cyc = 1; cyc <= 85; cyc++) begin
            tick();
            if (emit_start && !prev_start) begin
                if (n_grant < 5) begin
                    check_val("all_gnt_id",   {30'd0, grant_id}, {28'd0, exp_gnt[n_grant]});
                    check_val("all_gnt_cyc",  cyc, 1 + 20 * n_grant);
                    check_val("all_gnt_data", {16'd0, emit_data},
                              32'h1111 * (exp_gnt[n_grant] + 1));
                end
                n_grant++;
            end
            if (ack != 4'b0000) begin
                check_val("all_ack_onehot", {28'd0, ack}, 32'h1 << (n_ack % 4));
                n_ack++;
            end
            prev_start = emit_start;
        end
        check_val("all_n_grant", n_grant, 5);
        check_val("all_n_ack",   n_ack, 4);
        req = '0;

        // Data and req changes after grant are ignored
        do_reset();
        req             = 4'b0001;
        req_data[15:0]  = 16'h1234;
        tick();
        check_val("latch_gnt",  {30'd0, grant_id}, 32'h0);
        check_val("latch_data", {16'd0, emit_data}, 32'h1234);
        req             = 4'b0000;
        req_data[15:0]  = 16'hFFFF;
        capture_word(word);
        check_val("latch_serial",    {16'd0, word}, 32'h1234);
        check_val("latch_data_held", {16'd0, emit_data}, 32'h1234);
        tick();
        tick();
        check_val("latch_ack", {28'd0, ack}, 32'h1);
        tick();
        check_val("latch_idle", {31'd0, busy}, 32'h0);

        // Watchdog: done suppressed, rr_ptr = 1 so requester 2 first, then 0
        done_en        = 1'b0;
        req_data[15:0] = 16'h0F0F;
        req            = 4'b0101;
        tick();
        check_val("wd_gnt", {30'd0, grant_id}, 32'h2);
        acc_ack = '0;
        acc_err = 1'b0;
        for (int k = 0; k < 19; k++) begin
            tick();
            acc_ack = acc_ack | ack;
            acc_err = acc_err | err;
        end
        check_val("wd_start_t20", {31'd0, emit_start}, 32'h1);
        check_val("wd_no_ack",    {28'd0, acc_ack}, 32'h0);
        check_val("wd_no_early",  {31'd0, acc_err}, 32'h0);
        tick();
        check_val("wd_err",      {31'd0, err}, 32'h1);
        check_val("wd_ack",      {28'd0, ack}, 32'h0);
        check_val("wd_start_lo", {31'd0, emit_start}, 32'h0);
        tick();
        check_val("wd_err_gone", {31'd0, err}, 32'h0);
        check_val("wd_idle",     {31'd0, busy}, 32'h0);
        tick();
        check_val("wd_next_start", {31'd0, emit_start}, 32'h1);
        check_val("wd_next_gnt",   {30'd0, grant_id}, 32'h0);

        // Asynchronous reset at bit 7 of the transfer to requester 0
        for (int k = 0; k < 7; k++) tick();
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_start", {31'd0, emit_start}, 32'h0);
        check_val("arst_busy",  {31'd0, busy}, 32'h0);
        check_val("arst_data",  {16'd0, emit_data}, 32'h0);
        check_val("arst_gnt",   {30'd0, grant_id}, 32'h0);
        check_val("arst_ack",   {28'd0, ack}, 32'h0);
        check_val("arst_err",   {31'd0, err}, 32'h0);
        done_en = 1'b1;
        req     = 4'b1001;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_val("post_rst_gnt",   {30'd0, grant_id}, 32'h0);
        check_val("post_rst_data",  {16'd0, emit_data}, 32'h0F0F);
        check_val("post_rst_start", {31'd0, emit_start}, 32'h1);
        for (int k = 0; k < 18; k++) tick();
        check_val("post_rst_ack", {28'd0, ack}, 32'h1);
        req = '0;
        tick();
        tick();

        // TIMEOUT = 18: done and watchdog expiry coincide in SEND cycle 18
        req2              = 4'b0100;
        req_data2[47:32]  = 16'h5A5A;
        tick();
        check_val("sim_start", {31'd0, emit_start2}, 32'h1);
        check_val("sim_gnt",   {30'd0, grant_id2}, 32'h2);
        for (int k = 0; k < 17; k++) tick();
        check_val("sim_done_t18", {31'd0, serial_done2}, 32'h1);
        check_val("sim_ack_t18",  {28'd0, ack2}, 32'h0);
        tick();
        check_val("sim_ack_t19", {28'd0, ack2}, 32'h4);
        check_val("sim_err_t19", {31'd0, err2}, 32'h0);
        req2 = '0;
        tick();
        check_val("sim_err_t20",  {31'd0, err2}, 32'h0);
        check_val("sim_busy_t20", {31'd0, busy2}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/output_scheduler.md
# output_scheduler

Round-robin scheduler that shares a single `output_emitter` serializer between `NUM_REQ` requesters. It sits directly in front of the emitter: it grants one requester, latches that requester's word, drives the emitter's `data`/`start`, and waits for `serial_done`. It then acknowledges the requester and returns `start` low for one cycle so the emitter's bit counter clears. A watchdog aborts a transfer whose done never arrives.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 16: word width; must equal the emitter's `INPUT_WIDTH`.
- `TIMEOUT`, `DATA_WIDTH+4`: maximum SEND cycles before abort.

Ports:
- `fast_clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req`  in  `NUM_REQ`: per-requester request; held with data until `ack`.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`: requester i's word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ack`  out  `NUM_REQ`: one-cycle one-hot pulse on successful completion.
- `err`  out  1: one-cycle pulse on watchdog abort.
- `busy`  out  1: high in every state other than IDLE.
- `grant_id`  out  `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `emit_data`  out  `DATA_WIDTH`: to emitter `data`.
- `emit_start`  out  1: to emitter `start`.
- `emit_done`  in  1: from emitter `serial_done`.

## Operation
- States: IDLE, SEND, RELEASE (one-hot or 2-bit encoding).
- **IDLE**: if any `req` is set, select the first set bit searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Register `grant_id`, latch `emit_data` from that slice, and set `emit_start`=1.
  - Clear the watchdog and go to SEND.
- **SEND**: hold `emit_start`=1 and `emit_data` stable; the watchdog increments each cycle.
  - `emit_done`=1: go to RELEASE, set `emit_start`=0, pulse `ack[grant_id]`.
  - Otherwise, watchdog reaching `TIMEOUT`: go to RELEASE, set `emit_start`=0, pulse `err`, no `ack`.
- **RELEASE**: `emit_start` stays 0 for exactly one cycle, then go to IDLE. Set `rr_ptr` = `grant_id`+1, wrapping from `NUM_REQ`-1 to 0.
- `rr_ptr` advances after both ack and err, so a faulty requester cannot starve the others.
- Latched data: `req`/`req_data` changes after grant have no effect; the transfer completes with the latched word.
- A `req` dropped before being granted is simply not served. `req` bits are never stored.
- `emit_done` seen in IDLE or RELEASE is ignored.
- Reset values:
  - state IDLE, `rr_ptr`=0, `grant_id`=0, watchdog 0.
  - `emit_data`=0, `emit_start`=0.
  - `ack`=0, `err`=0, `busy`=0.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous). No `ack` or `err` is produced for the lost transfer.

## Timing
- All outputs are registered; there is no combinational path from `req` or `emit_done` to any output.
- `req` high in IDLE in cycle t gives `emit_start`=1, `busy`=1 and valid `emit_data` in cycle t+1.
- With the emitter attached, `emit_done` rises in cycle t+`DATA_WIDTH`+2.
- `ack` pulses in cycle t+`DATA_WIDTH`+3 (the RELEASE cycle).
- IDLE is re-entered at t+`DATA_WIDTH`+4. A pending request is granted in that same cycle.
- Back-to-back period is therefore `DATA_WIDTH`+4 cycles per word: 20 at the default width.
- The `emit_start`-low cycle in RELEASE guarantees the emitter clears its counter and `serial_done` before the next start.
- Timeout: `err` pulses in the cycle after the `TIMEOUT`-th SEND cycle.
- Simultaneous events: `emit_done` arriving in the same cycle the watchdog reaches `TIMEOUT` is treated as success (ack, not err).

## Structure
- Shared package `output_pkg`:
  - state enum (`ST_IDLE`, `ST_SEND`, `ST_RELEASE`);
  - default-width constant `OUT_DATA_WIDTH`=16, shared with the emitter's parameter.
- Sub-module `rr_arbiter`: combinational round-robin pick.
  - Inputs: `req`, `rr_ptr`.
  - Outputs: `valid`, `grant_idx`.
  - Instantiated once. All state remains in `output_scheduler`.
- The bench instantiates `output_scheduler` plus `output_emitter`. The emitter's active-low reset is driven from the inverted `reset`.

## Test plan
- **Single request**: `req`=0010, slice 1 = 0xA5C3 → `serial_out` emits 0xA5C3 LSB-first and `grant_id`=1. `ack`=0010 for one cycle at t+19, `busy` low at t+20.
- **All requesting**: `req`=1111 held continuously → grant order 0,1,2,3,0. Grants are spaced exactly 20 cycles apart, with one `ack` per transfer.
- **Data change after grant**: `req_data` changed during SEND → emitted word is the latched value.
  - Also: `req` dropped during SEND → `ack` is still produced.
- **Watchdog**: `emit_done` tied 0 → `err` pulses after 20 SEND cycles with no `ack`. `emit_start` is low for one cycle, then the next requester is granted.
- **Reset mid-SEND**: assert `reset` at bit 7 of a transfer → all outputs 0 asynchronously. After release, `rr_ptr`=0, so requester 0 wins first.
- **Simultaneous done and timeout**: with `TIMEOUT`=`DATA_WIDTH`+2 and `emit_done` rising in SEND cycle 18 → `ack` pulses and `err` stays 0.
